clk_rst_gen: RTL and testbench

CLK_RST_GEN -- requirements
Module: clk_rst_gen

---
 rtl/clk_rst_pkg.sv | 18 +
 rtl/clk_rst_gen_ce_div.sv | 63 ++++++
 rtl/clk_rst_gen.sv | 120 ++++++++++++
 tb/tb_clk_rst_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared definitions for the clock-enable / reset generator.
// Holds the sequencer state encoding and the default parameter values.
package clk_rst_pkg;

  localparam int unsigned N_CH_DEF      = 4;
  localparam int unsigned DIV_W_DEF     = 16;
  localparam int unsigned STRETCH_W_DEF = 4;
  localparam int unsigned LOCK_FILT_DEF = 8;
  localparam int unsigned LOST_W        = 8;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STRETCH   = 2'd2,
    RUN       = 2'd3
  } state_e;

endpackage

// File: rtl/clk_rst_gen_ce_div.sv
// One clock-enable channel: free-running counter, shadow divider and active
// divider. The shadow only reaches the active divider at a wrap (or at any
// time outside RUN), so a period is never cut short by a reload.
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   run        sequencer is in RUN this cycle
//   run_nxt    sequencer will be in RUN next cycle
//   wr_en      write wr_div into the shadow register
//   wr_div     new divide value
//   ce         registered one-cycle enable strobe
module ce_div
  import clk_rst_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             run_nxt,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic             ce_q, ce_d;
  logic             wrap;

  // Next counter/divider values; ce is precomputed for the coming cycle
  always_comb begin
    shd_d = wr_en ? wr_div : shd_q;
    wrap  = (cnt_q == act_q);
    cnt_d = (run && run_nxt && !wrap) ? cnt_q + DIV_W'(1) : '0;
    if (!run) begin
      act_d = shd_d;
    end else if (wrap) begin
      // Old shadow: a write landing on the wrap cycle waits for the next wrap
      act_d = shd_q;
    end else begin
      act_d = act_q;
    end
    ce_d = run_nxt && (cnt_d == act_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      shd_q <= '0;
      act_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      shd_q <= shd_d;
      act_q <= act_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/clk_rst_gen.sv
// Reset sequencer and clock-enable generator. Filters pll_lock, stretches the
// system reset after lock, and drives N_CH programmable enable strobes in RUN.
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   pll_lock        raw lock indication (clk domain)
//   cfg_valid/ready divider-load handshake; cfg_ch selects channel, cfg_div value
//   sys_rst         active-high stretched system reset
//   ce              per-channel one-cycle enable strobes
//   lock_lost_cnt   saturating count of lock-loss events while in RUN
module clk_rst_gen
  import clk_rst_pkg::*;
#(
  parameter int unsigned N_CH      = N_CH_DEF,
  parameter int unsigned DIV_W     = DIV_W_DEF,
  parameter int unsigned STRETCH_W = STRETCH_W_DEF,
  parameter int unsigned LOCK_FILT = LOCK_FILT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              sys_rst,
  output logic [N_CH-1:0]   ce,
  output logic [LOST_W-1:0] lock_lost_cnt
);

  localparam int unsigned LF_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;

  state_e              state_q, state_d;
  logic [LF_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [STRETCH_W-1:0] str_cnt_q, str_cnt_d;
  logic [LOST_W-1:0]   lost_q, lost_d;
  logic                sys_rst_q, sys_rst_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                in_run, run_nxt, cfg_fire;

  // Sequencer next state; counters clear whenever their state is left
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    str_cnt_d  = '0;
    lost_d     = lost_q;
    case (state_q)
      HOLD: state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (pll_lock) begin
          if (lock_cnt_q == LF_W'(LOCK_FILT - 1)) begin
            state_d = STRETCH;
          end else begin
            lock_cnt_d = lock_cnt_q + LF_W'(1);
          end
        end
      end
      STRETCH: begin
        if (!pll_lock) begin
          state_d = WAIT_LOCK;
        end else if (str_cnt_q == '1) begin
          state_d = RUN;
        end else begin
          str_cnt_d = str_cnt_q + STRETCH_W'(1);
        end
      end
      RUN: begin
        if (!pll_lock) begin
          state_d = WAIT_LOCK;
          if (lost_q != '1) begin
            lost_d = lost_q + LOST_W'(1);
          end
        end
      end
      default: state_d = HOLD;
    endcase
    sys_rst_d   = (state_d != RUN);
    cfg_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HOLD;
      lock_cnt_q  <= '0;
      str_cnt_q   <= '0;
      lost_q      <= '0;
      sys_rst_q   <= 1'b1;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      str_cnt_q   <= str_cnt_d;
      lost_q      <= lost_d;
      sys_rst_q   <= sys_rst_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign in_run        = (state_q == RUN);
  assign run_nxt       = (state_d == RUN);
  assign cfg_fire      = cfg_valid && cfg_ready_q;
  assign sys_rst       = sys_rst_q;
  assign cfg_ready     = cfg_ready_q;
  assign lock_lost_cnt = lost_q;

  // Out-of-range channel indices match no instance and are dropped
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ce_div #(
      .DIV_W (DIV_W)
    ) u_ce_div (
      .clk     (clk),
      .rst     (rst),
      .run     (in_run),
      .run_nxt (run_nxt),
      .wr_en   (cfg_fire && (cfg_ch == 3'(i))),
      .wr_div  (cfg_div),
      .ce      (ce[i])
    );
  end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Directed scoreboard bench for clk_rst_gen.
module tb_clk_rst_gen;

  localparam int N_CH  = 4;
  localparam int DIV_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              pll_lock;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              sys_rst;
  logic [N_CH-1:0]   ce;
  logic [7:0]        lock_lost_cnt;

  clk_rst_gen dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ch        (cfg_ch),
    .cfg_div       (cfg_div),
    .sys_rst       (sys_rst),
    .ce            (ce),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input int obs);
    exp_t e;
    e = sb.pop_front();
    n_vec++;
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Cycles until sys_rst is seen low; optional one-cycle lock drop after
  // glitch_at filter cycles. Returns 200 if the budget runs out.
  task automatic start_up(input int glitch_at, output int k);
    k = 0;
    while (k < 200) begin
      tick();
      k++;
      if (glitch_at > 0 && k == glitch_at + 1) pll_lock = 1'b0;
      if (glitch_at > 0 && k == glitch_at + 2) pll_lock = 1'b1;
      if (sys_rst === 1'b0) break;
    end
  endtask

  // Cycles until the next ce[ch] pulse; -1 if none within budget
  task automatic wait_ce(input int ch, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ce[ch] !== 1'b1 && n < budget);
    if (ce[ch] !== 1'b1) n = -1;
  endtask

  task automatic cfg_write(input int ch, input int div);
    cfg_ch    = 3'(ch);
    cfg_div   = DIV_W'(div);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int k;
    int n;
    int ones;
    rst       = 1'b0;
    pll_lock  = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;

    // Reset values
    repeat (3) tick();
    expect_val("rst_sys_rst", 1);   check(int'(sys_rst));
    expect_val("rst_ce", 0);        check(int'(ce));
    expect_val("rst_cfg_ready", 0); check(int'(cfg_ready));
    expect_val("rst_lost_cnt", 0);  check(int'(lock_lost_cnt));

    // Clean start: 1 + 8 + 16 cycles
    rst = 1'b1;
    expect_val("clean_start_cycles", 25);
    start_up(0, k);
    check(k);
    expect_val("run_cfg_ready", 1); check(int'(cfg_ready));
    expect_val("run_ce_div0", 15);  check(int'(ce));

    // Lock glitch at filter count 5 costs 6 cycles
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    expect_val("glitch_start_cycles", 31);
    start_up(5, k);
    check(k);

    // ch0 divider 3 -> period 4, width 1
    cfg_write(0, 3);
    wait_ce(0, 20, n);
    expect_val("ch0_period_a", 4); wait_ce(0, 20, n); check(n);
    expect_val("ch0_period_b", 4); wait_ce(0, 20, n); check(n);
    tick();
    expect_val("ch0_width", 0); check(int'(ce[0]));

    // Out-of-range channel write must not disturb any channel
    cfg_write(4, 7);
    expect_val("oor_ch3_const", 1); check(int'(ce[3]));
    wait_ce(0, 20, n);
    expect_val("oor_ch0_period", 4); wait_ce(0, 20, n); check(n);

    // ch1 div 9 then reload 2 mid-period
    cfg_write(1, 9);
    wait_ce(1, 30, n);
    expect_val("ch1_period_9", 10); wait_ce(1, 30, n); check(n);
    repeat (3) tick();
    cfg_write(1, 2);
    expect_val("ch1_reload_finish", 10); wait_ce(1, 30, n); check(n + 4);
    expect_val("ch1_period_2a", 3); wait_ce(1, 30, n); check(n);
    expect_val("ch1_period_2b", 3); wait_ce(1, 30, n); check(n);

    // Back-to-back writes to ch2: last value (1) wins
    cfg_ch    = 3'd2;
    cfg_div   = DIV_W'(6);
    cfg_valid = 1'b1;
    tick();
    cfg_div   = DIV_W'(1);
    tick();
    cfg_valid = 1'b0;
    wait_ce(2, 30, n);
    expect_val("ch2_b2b_a", 2); wait_ce(2, 30, n); check(n);
    expect_val("ch2_b2b_b", 2); wait_ce(2, 30, n); check(n);

    // Lock loss in RUN
    expect_val("pre_loss_ce3", 1);   check(int'(ce[3]));
    expect_val("pre_loss_cnt", 0);   check(int'(lock_lost_cnt));
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    expect_val("loss_sys_rst", 1); check(int'(sys_rst));
    expect_val("loss_ce", 0);      check(int'(ce));
    expect_val("loss_cnt_1", 1);   check(int'(lock_lost_cnt));
    expect_val("relock_cycles", 24);
    start_up(0, k);
    check(k);
    for (int i = 0; i < 299; i++) begin
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      start_up(0, k);
    end
    expect_val("loss_cnt_sat", 255); check(int'(lock_lost_cnt));

    // Mid-operation reset with ch2 div 5; cfg traffic during reset is ignored
    cfg_write(2, 5);
    repeat (8) tick();
    rst       = 1'b0;
    cfg_ch    = 3'd2;
    cfg_div   = DIV_W'(9);
    cfg_valid = 1'b1;
    tick();
    expect_val("mid_rst_sys_rst", 1);   check(int'(sys_rst));
    expect_val("mid_rst_ce", 0);        check(int'(ce));
    expect_val("mid_rst_cfg_ready", 0); check(int'(cfg_ready));
    expect_val("mid_rst_lost_cnt", 0);  check(int'(lock_lost_cnt));
    tick();
    cfg_valid = 1'b0;
    rst       = 1'b1;
    expect_val("mid_rst_restart", 25);
    start_up(0, k);
    check(k);
    ones = (ce === 4'hF) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ce === 4'hF) ones++;
    end
    expect_val("mid_rst_div_zero", 6); check(ones);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
